// File: rtl/ddr_if_pkg.sv
// Shared definitions for the 14-bit DDR link gearboxes (2to5 receive, 5to2 transmit).
package ddr_if_pkg;

  localparam int unsigned WORD_W     = 14;
  localparam int unsigned TX_WORDS   = 5;
  localparam int unsigned LINE_WORDS = 2;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t SYNC_WORD = 14'h2A5C;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } align_state_t;

  function automatic logic is_sync(input word_t w);
    return w == SYNC_WORD;
  endfunction

endpackage

// File: rtl/ddr_if_gearbox_2to5.sv
// 2-word to 5-word regrouping buffer with single-word slip.
// Optional slip strobe output when DDR_IF_2TO5_STATS_EN is defined.
module ddr_if_gearbox_2to5
  import ddr_if_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  word_t [LINE_WORDS-1:0] i_data,
  input  logic                   i_valid,
  input  logic                   i_slip_req,
  input  logic                   i_slip_clr,
  output word_t [TX_WORDS-1:0]   o_frame,
  output logic                   o_valid
`ifdef DDR_IF_2TO5_STATS_EN
  ,
  output logic                   o_slip_done
`endif
);

  localparam int unsigned BUF_WORDS = TX_WORDS + 1;

  word_t [BUF_WORDS-1:0] r_buf;
  word_t [BUF_WORDS-1:0] w_buf;
  word_t [BUF_WORDS-1:0] w_rest;
  word_t [TX_WORDS-1:0]  r_frame;
  logic  [2:0]           r_cnt;
  logic  [2:0]           w_cnt;
  logic  [2:0]           w_rest_cnt;
  logic                  r_valid;
  logic                  r_slip_pend;
  logic                  w_slip;
  logic                  w_do_slip;
  logic                  w_emit;

  // Append, then drop, then emit test on the post-drop count, all within one beat.
  always_comb begin
    w_slip     = (r_slip_pend | i_slip_req) & ~i_slip_clr;
    w_buf      = r_buf;
    w_cnt      = r_cnt;
    w_do_slip  = 1'b0;
    if (i_valid) begin
      for (int unsigned i = 0; i < BUF_WORDS; i++) begin
        if (3'(i) == r_cnt)         w_buf[i] = i_data[0];
        if (3'(i) == r_cnt + 3'd1)  w_buf[i] = i_data[1];
      end
      w_cnt = r_cnt + 3'd2;
      if (w_slip) begin
        for (int unsigned i = 0; i < BUF_WORDS - 1; i++) begin
          w_buf[i] = w_buf[i+1];
        end
        w_buf[BUF_WORDS-1] = '0;
        w_cnt     = w_cnt - 3'd1;
        w_do_slip = 1'b1;
      end
    end
    w_emit     = i_valid && (w_cnt >= 3'(TX_WORDS));
    w_rest     = w_buf;
    w_rest_cnt = w_cnt;
    if (w_emit) begin
      w_rest     = '0;
      w_rest[0]  = w_buf[TX_WORDS];
      w_rest_cnt = w_cnt - 3'(TX_WORDS);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_slip_pend <= 1'b0;
      r_frame     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_buf       <= w_rest;
      r_cnt       <= w_rest_cnt;
      r_slip_pend <= w_slip & ~w_do_slip;
      r_valid     <= w_emit;
      if (w_emit) r_frame <= w_buf[TX_WORDS-1:0];
    end
  end

  assign o_frame = r_frame;
  assign o_valid = r_valid;

`ifdef DDR_IF_2TO5_STATS_EN
  assign o_slip_done = w_do_slip;
`endif

endmodule

// File: rtl/ddr_if_2to5.sv
// Receive gearbox top: 2-word DDR beats to 5-word frames with SYNC_WORD alignment FSM.
// Define DDR_IF_2TO5_STATS_EN to add slip_count / frame_count outputs.
module ddr_if_2to5 #(
  parameter int unsigned WORD_W     = 14,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned SLIP_WAIT  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0][WORD_W-1:0] data_in,
  input  logic                   in_valid,
  input  logic                   train,
  input  logic                   relock,
  output logic [4:0][WORD_W-1:0] data_out,
  output logic                   out_valid,
  output logic                   locked
`ifdef DDR_IF_2TO5_STATS_EN
  ,
  output logic [15:0]            slip_count,
  output logic [31:0]            frame_count
`endif
);
  import ddr_if_pkg::*;

  localparam int unsigned MC_W = $clog2(LOCK_COUNT + 2);
  localparam int unsigned WC_W = $clog2(SLIP_WAIT + 2);

  align_state_t          r_state;
  logic [MC_W-1:0]       r_match_cnt;
  logic [WC_W-1:0]       r_wait_cnt;
  logic                  r_slip_req;
  logic                  r_locked;
  logic [4:0][WORD_W-1:0] w_frame;
  logic                  w_valid;
`ifdef DDR_IF_2TO5_STATS_EN
  logic                  w_slip_done;
`endif

  ddr_if_gearbox_2to5 u_gearbox (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_data     (data_in),
    .i_valid    (in_valid),
    .i_slip_req (r_slip_req),
    .i_slip_clr (relock),
    .o_frame    (w_frame),
    .o_valid    (w_valid)
`ifdef DDR_IF_2TO5_STATS_EN
    ,
    .o_slip_done(w_slip_done)
`endif
  );

  // Each emitted frame is judged the cycle it is presented; slip request is a 1-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= HUNT;
      r_match_cnt <= '0;
      r_wait_cnt  <= '0;
      r_slip_req  <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_slip_req <= 1'b0;
      if (relock) begin
        r_state     <= HUNT;
        r_match_cnt <= '0;
        r_wait_cnt  <= '0;
        r_locked    <= 1'b0;
      end else if (w_valid && train) begin
        case (r_state)
          HUNT: begin
            if (r_wait_cnt != '0) begin
              r_wait_cnt <= r_wait_cnt - WC_W'(1);
            end else if (is_sync(w_frame[0])) begin
              if (LOCK_COUNT <= 1) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_state     <= VERIFY;
                r_match_cnt <= MC_W'(1);
              end
            end else begin
              r_slip_req <= 1'b1;
              r_wait_cnt <= WC_W'(SLIP_WAIT);
            end
          end
          VERIFY: begin
            if (is_sync(w_frame[0])) begin
              if (r_match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_match_cnt <= r_match_cnt + MC_W'(1);
              end
            end else begin
              r_state     <= HUNT;
              r_match_cnt <= '0;
              r_slip_req  <= 1'b1;
              r_wait_cnt  <= WC_W'(SLIP_WAIT);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out  = w_frame;
  assign out_valid = w_valid;
  assign locked    = r_locked;

`ifdef DDR_IF_2TO5_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slip_count  <= '0;
      frame_count <= '0;
    end else if (relock) begin
      slip_count  <= '0;
      frame_count <= '0;
    end else begin
      if (w_slip_done && slip_count != '1) slip_count <= slip_count + 16'd1;
      if (w_valid) frame_count <= frame_count + 32'd1;
    end
  end
`endif

endmodule
